// File: rtl/uart_frame_loader_if.sv
// Cell-load bus between the UART frame loader and the cell array.
// Carries the serial input into the loader and the loader's write strobe,
// address/data, frame status pulses and busy flag out to the array.
//   uart_rx     serial line, idle high
//   cell_we     one-cycle write strobe qualifying cell_addr/cell_data
//   cell_addr   cell index
//   cell_data   assembled 32-bit cell value
//   frame_done  pulse with the final cell write of a frame
//   frame_err   pulse on framing error or payload timeout
//   busy        frame reception in progress
interface uart_frame_loader_if #(
   parameter int ADDR_W = 5
);
   logic              uart_rx;
   logic              cell_we;
   logic [ADDR_W-1:0] cell_addr;
   logic [31:0]       cell_data;
   logic              frame_done;
   logic              frame_err;
   logic              busy;

   modport master (
      input  uart_rx,
      output cell_we,
      output cell_addr,
      output cell_data,
      output frame_done,
      output frame_err,
      output busy
   );

   modport slave (
      output uart_rx,
      input  cell_we,
      input  cell_addr,
      input  cell_data,
      input  frame_done,
      input  frame_err,
      input  busy
   );
endinterface

// File: rtl/uart_frame_loader.sv
// UART 8N1 receiver and frame parser feeding the wave solver's cell array.
// A frame is HDR_LEN header bytes followed by N_CELLS little-endian 32-bit
// cell values, cell 0 first. Each completed cell produces one write strobe.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_frame_loader_if.master (uart_rx in; cell_we, cell_addr,
//          cell_data, frame_done, frame_err, busy out)
//
// Bit FSM
//   state   | meaning
//   B_IDLE  | line idle, waiting for a falling edge
//   B_START | half a bit time into the start bit, checking it is still low
//   B_DATA  | sampling 8 data bits LSB first, one bit time apart
//   B_STOP  | sampling the stop bit, then straight back to idle
// Frame FSM
//   state     | meaning
//   F_HUNT    | counting consecutive header bytes
//   F_PAYLOAD | assembling cell words, timeout armed between bytes
module uart_frame_loader #(
   parameter int         CLKS_PER_BIT = 235,
   parameter int         N_CELLS      = 20,
   parameter int         ADDR_W       = 5,
   parameter logic [7:0] HDR_BYTE     = 8'h01,
   parameter int         HDR_LEN      = 4,
   parameter int         TIMEOUT_CLKS = 4700
) (
   input logic                 clk,
   input logic                 rst_n,
   uart_frame_loader_if.master bus
);

   localparam int BIT_W = $clog2(CLKS_PER_BIT);
   localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
   localparam int HDR_W = $clog2(HDR_LEN + 1);

   localparam logic [BIT_W-1:0]  HALF_BIT    = BIT_W'(CLKS_PER_BIT / 2);
   localparam logic [BIT_W-1:0]  FULL_BIT_M1 = BIT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE     = BIT_W'(1);
   localparam logic [TO_W-1:0]   TO_LOAD     = TO_W'(TIMEOUT_CLKS - 1);
   localparam logic [TO_W-1:0]   TO_ONE      = TO_W'(1);
   localparam logic [HDR_W-1:0]  HDR_LAST    = HDR_W'(HDR_LEN - 1);
   localparam logic [HDR_W-1:0]  HDR_ONE     = HDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_CELL   = ADDR_W'(N_CELLS - 1);
   localparam logic [ADDR_W-1:0] CELL_ONE    = ADDR_W'(1);

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
   typedef enum logic {F_HUNT, F_PAYLOAD} frame_state_t;

   logic              rx_meta_q, rx_meta_d;
   logic              rx_sync_q, rx_sync_d;
   logic              rx_prev_q, rx_prev_d;

   bit_state_t        bit_state_q, bit_state_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;

   frame_state_t      frame_state_q, frame_state_d;
   logic [HDR_W-1:0]  hdr_cnt_q, hdr_cnt_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [ADDR_W-1:0] cell_idx_q, cell_idx_d;
   logic [23:0]       word_q, word_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

   logic              cell_we_q, cell_we_d;
   logic [ADDR_W-1:0] cell_addr_q, cell_addr_d;
   logic [31:0]       cell_data_q, cell_data_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;
   logic              busy_q, busy_d;

   logic              start_edge;
   logic              byte_ok;
   logic              byte_bad;

   assign start_edge = rx_prev_q & ~rx_sync_q;

   always_comb begin
      rx_meta_d     = bus.uart_rx;
      rx_sync_d     = rx_meta_q;
      rx_prev_d     = rx_sync_q;
      bit_state_d   = bit_state_q;
      bit_cnt_d     = bit_cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      frame_state_d = frame_state_q;
      hdr_cnt_d     = hdr_cnt_q;
      byte_idx_d    = byte_idx_q;
      cell_idx_d    = cell_idx_q;
      word_d        = word_q;
      to_cnt_d      = to_cnt_q;
      cell_we_d     = 1'b0;
      cell_addr_d   = cell_addr_q;
      cell_data_d   = cell_data_q;
      frame_done_d  = 1'b0;
      frame_err_d   = 1'b0;
      busy_d        = busy_q;
      byte_ok       = 1'b0;
      byte_bad      = 1'b0;

      case (bit_state_q)
         B_IDLE: begin
            if (start_edge) begin
               bit_state_d = B_START;
               bit_cnt_d   = HALF_BIT;
            end
         end
         B_START: begin
            if (bit_cnt_q == '0) begin
               if (rx_sync_q) begin
                  bit_state_d = B_IDLE;
               end else begin
                  bit_state_d = B_DATA;
                  bit_cnt_d   = FULL_BIT_M1;
                  bit_idx_d   = 3'd0;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - BIT_ONE;
            end
         end
         B_DATA: begin
            if (bit_cnt_q == '0) begin
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_cnt_d = FULL_BIT_M1;
               if (bit_idx_q == 3'd7) begin
                  bit_state_d = B_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - BIT_ONE;
            end
         end
         B_STOP: begin
            // Return to idle right at the stop sample so a start edge in the
            // back half of the stop bit is not missed.
            if (bit_cnt_q == '0) begin
               bit_state_d = B_IDLE;
               byte_ok     = rx_sync_q;
               byte_bad    = ~rx_sync_q;
            end else begin
               bit_cnt_d = bit_cnt_q - BIT_ONE;
            end
         end
         default: bit_state_d = B_IDLE;
      endcase

      if (byte_bad) begin
         frame_err_d   = 1'b1;
         frame_state_d = F_HUNT;
         hdr_cnt_d     = '0;
         busy_d        = 1'b0;
      end else if (byte_ok) begin
         case (frame_state_q)
            F_HUNT: begin
               if (shift_q == HDR_BYTE) begin
                  busy_d = 1'b1;
                  if (hdr_cnt_q == HDR_LAST) begin
                     frame_state_d = F_PAYLOAD;
                     hdr_cnt_d     = '0;
                     byte_idx_d    = 2'd0;
                     cell_idx_d    = '0;
                     to_cnt_d      = TO_LOAD;
                  end else begin
                     hdr_cnt_d = hdr_cnt_q + HDR_ONE;
                  end
               end else begin
                  hdr_cnt_d = '0;
                  busy_d    = 1'b0;
               end
            end
            F_PAYLOAD: begin
               to_cnt_d   = TO_LOAD;
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: word_d[7:0]   = shift_q;
                  2'd1: word_d[15:8]  = shift_q;
                  2'd2: word_d[23:16] = shift_q;
                  default: begin
                     cell_we_d   = 1'b1;
                     cell_addr_d = cell_idx_q;
                     cell_data_d = {shift_q, word_q};
                     if (cell_idx_q == LAST_CELL) begin
                        frame_done_d  = 1'b1;
                        frame_state_d = F_HUNT;
                        hdr_cnt_d     = '0;
                        busy_d        = 1'b0;
                     end else begin
                        cell_idx_d = cell_idx_q + CELL_ONE;
                     end
                  end
               endcase
            end
            default: frame_state_d = F_HUNT;
         endcase
      end else if (frame_state_q == F_PAYLOAD && bit_state_q == B_IDLE && !start_edge) begin
         // A start edge on the expiry cycle takes precedence, hence !start_edge.
         if (to_cnt_q == '0) begin
            frame_err_d   = 1'b1;
            frame_state_d = F_HUNT;
            hdr_cnt_d     = '0;
            busy_d        = 1'b0;
         end else begin
            to_cnt_d = to_cnt_q - TO_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
         rx_prev_q     <= 1'b1;
         bit_state_q   <= B_IDLE;
         bit_cnt_q     <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         frame_state_q <= F_HUNT;
         hdr_cnt_q     <= '0;
         byte_idx_q    <= '0;
         cell_idx_q    <= '0;
         word_q        <= '0;
         to_cnt_q      <= '0;
         cell_we_q     <= 1'b0;
         cell_addr_q   <= '0;
         cell_data_q   <= '0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         rx_meta_q     <= rx_meta_d;
         rx_sync_q     <= rx_sync_d;
         rx_prev_q     <= rx_prev_d;
         bit_state_q   <= bit_state_d;
         bit_cnt_q     <= bit_cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         frame_state_q <= frame_state_d;
         hdr_cnt_q     <= hdr_cnt_d;
         byte_idx_q    <= byte_idx_d;
         cell_idx_q    <= cell_idx_d;
         word_q        <= word_d;
         to_cnt_q      <= to_cnt_d;
         cell_we_q     <= cell_we_d;
         cell_addr_q   <= cell_addr_d;
         cell_data_q   <= cell_data_d;
         frame_done_q  <= frame_done_d;
         frame_err_q   <= frame_err_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.cell_we    = cell_we_q;
   assign bus.cell_addr  = cell_addr_q;
   assign bus.cell_data  = cell_data_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.busy       = busy_q;

endmodule
